// File: rtl/coin_pkg.sv
// Shared coin values and controller state encoding for the coin credit accumulator.
package coin_pkg;

    localparam int DEF_QUARTER_VAL = 25;
    localparam int DEF_DIME_VAL    = 10;
    localparam int DEF_NICKEL_VAL  = 5;

    typedef enum logic {
        IDLE   = 1'b0,
        CHANGE = 1'b1
    } state_t;

endpackage

// File: rtl/coin_edge_detect.sv
// Rising-edge detector for a sensor level; history resets high so a level held
// through reset release is not seen as an edge.
module coin_edge_detect (
    input  logic clk,
    input  logic i_rst,
    input  logic i_level,
    output logic o_edge
);

    logic r_prev;

    always_ff @(posedge clk) begin
        if (i_rst) r_prev <= 1'b1;
        else       r_prev <= i_level;
    end

    assign o_edge = i_level & ~r_prev;

endmodule

// File: rtl/coin_credit_accumulator.sv
// Coin credit accumulator: edge-detected coin entry with saturation, vend/refund
// handling and greedy one-coin-per-cycle change dispensing.
module coin_credit_accumulator
    import coin_pkg::*;
#(
    parameter int COUNT_W     = 10,
    parameter int QUARTER_VAL = DEF_QUARTER_VAL,
    parameter int DIME_VAL    = DEF_DIME_VAL,
    parameter int NICKEL_VAL  = DEF_NICKEL_VAL,
    parameter int PRICE       = 65,
    parameter int MAX_CREDIT  = 255
) (
    input  logic               clk,
    input  logic               resetCount,
    input  logic               inQuarter,
    input  logic               inDime,
    input  logic               inNickel,
    input  logic               inVend,
    input  logic               inRefund,
    output logic [COUNT_W-1:0] outCount,
    output logic               outVendOk,
    output logic               outVendDeny,
    output logic               outCoinReject,
    output logic               outChangeQuarter,
    output logic               outChangeDime,
    output logic               outChangeNickel,
    output logic               outBusy
);

    localparam logic [COUNT_W-1:0] LP_QV    = COUNT_W'(QUARTER_VAL);
    localparam logic [COUNT_W-1:0] LP_DV    = COUNT_W'(DIME_VAL);
    localparam logic [COUNT_W-1:0] LP_NV    = COUNT_W'(NICKEL_VAL);
    localparam logic [COUNT_W-1:0] LP_PRICE = COUNT_W'(PRICE);
    localparam logic [COUNT_W:0]   LP_MAX   = (COUNT_W+1)'(MAX_CREDIT);

    logic w_edge_q, w_edge_d, w_edge_n, w_edge_v, w_edge_r;

    coin_edge_detect u_ed_q (.clk(clk), .i_rst(resetCount), .i_level(inQuarter), .o_edge(w_edge_q));
    coin_edge_detect u_ed_d (.clk(clk), .i_rst(resetCount), .i_level(inDime),    .o_edge(w_edge_d));
    coin_edge_detect u_ed_n (.clk(clk), .i_rst(resetCount), .i_level(inNickel),  .o_edge(w_edge_n));
    coin_edge_detect u_ed_v (.clk(clk), .i_rst(resetCount), .i_level(inVend),    .o_edge(w_edge_v));
    coin_edge_detect u_ed_r (.clk(clk), .i_rst(resetCount), .i_level(inRefund),  .o_edge(w_edge_r));

    state_t             r_state;
    logic [COUNT_W-1:0] r_credit;
    logic               r_vend_ok, r_vend_deny, r_coin_reject;
    logic               r_chg_q, r_chg_d, r_chg_n;

    logic [COUNT_W:0]   w_sum;
    logic [COUNT_W:0]   w_credit_sum;
    logic               w_any_coin;
    logic               w_act_refund;
    logic               w_act_vend;
    logic [COUNT_W-1:0] w_change_coin;
    logic [COUNT_W-1:0] w_change_left;
    logic [COUNT_W-1:0] w_vend_left;

    assign w_any_coin   = w_edge_q | w_edge_d | w_edge_n;
    assign w_sum        = (w_edge_q ? {1'b0, LP_QV} : '0)
                        + (w_edge_d ? {1'b0, LP_DV} : '0)
                        + (w_edge_n ? {1'b0, LP_NV} : '0);
    assign w_credit_sum = {1'b0, r_credit} + w_sum;

    // A refund with no credit is a no-op and does not block coins; it still
    // masks a simultaneous vend.
    assign w_act_refund = w_edge_r && (r_credit != '0);
    assign w_act_vend   = !w_edge_r && w_edge_v;

    assign w_change_coin = (r_credit >= LP_QV) ? LP_QV :
                           (r_credit >= LP_DV) ? LP_DV : LP_NV;
    assign w_change_left = r_credit - w_change_coin;
    assign w_vend_left   = r_credit - LP_PRICE;

    always_ff @(posedge clk) begin
        if (resetCount) begin
            r_state       <= IDLE;
            r_credit      <= '0;
            r_vend_ok     <= 1'b0;
            r_vend_deny   <= 1'b0;
            r_coin_reject <= 1'b0;
            r_chg_q       <= 1'b0;
            r_chg_d       <= 1'b0;
            r_chg_n       <= 1'b0;
        end else begin
            r_vend_ok     <= 1'b0;
            r_vend_deny   <= 1'b0;
            r_coin_reject <= 1'b0;
            r_chg_q       <= 1'b0;
            r_chg_d       <= 1'b0;
            r_chg_n       <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_act_refund) begin
                        r_state       <= CHANGE;
                        r_coin_reject <= w_any_coin;
                    end else if (w_act_vend) begin
                        r_coin_reject <= w_any_coin;
                        if (r_credit >= LP_PRICE) begin
                            r_vend_ok <= 1'b1;
                            r_credit  <= w_vend_left;
                            if (w_vend_left != '0) r_state <= CHANGE;
                        end else begin
                            r_vend_deny <= 1'b1;
                        end
                    end else if (w_any_coin) begin
                        if (w_credit_sum > LP_MAX) r_coin_reject <= 1'b1;
                        else                       r_credit <= w_credit_sum[COUNT_W-1:0];
                    end
                end
                CHANGE: begin
                    r_coin_reject <= w_any_coin;
                    r_credit      <= w_change_left;
                    r_chg_q       <= (w_change_coin == LP_QV);
                    r_chg_d       <= (w_change_coin == LP_DV);
                    r_chg_n       <= (w_change_coin == LP_NV);
                    if (w_change_left == '0) r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign outCount         = r_credit;
    assign outVendOk        = r_vend_ok;
    assign outVendDeny      = r_vend_deny;
    assign outCoinReject    = r_coin_reject;
    assign outChangeQuarter = r_chg_q;
    assign outChangeDime    = r_chg_d;
    assign outChangeNickel  = r_chg_n;
    assign outBusy          = (r_state == CHANGE);

endmodule

// File: tb/tb_coin_credit_accumulator.sv
// Bench for coin_credit_accumulator: directed scenarios plus a randomized run
// against a queue-based credit model, on a default and a low-ceiling instance.
module tb_coin_credit_accumulator;

    localparam int QV = 25;
    localparam int DV = 10;
    localparam int NV = 5;
    localparam int PRICE = 65;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic resetCount = 1'b1;
    logic inQuarter = 1'b0, inDime = 1'b0, inNickel = 1'b0, inVend = 1'b0, inRefund = 1'b0;

    logic [9:0] cnt0, cnt1;
    logic ok0, deny0, rej0, cq0, cd0, cn0, busy0;
    logic ok1, deny1, rej1, cq1, cd1, cn1, busy1;

    coin_credit_accumulator u_dut (
        .clk(clk), .resetCount(resetCount),
        .inQuarter(inQuarter), .inDime(inDime), .inNickel(inNickel),
        .inVend(inVend), .inRefund(inRefund),
        .outCount(cnt0), .outVendOk(ok0), .outVendDeny(deny0), .outCoinReject(rej0),
        .outChangeQuarter(cq0), .outChangeDime(cd0), .outChangeNickel(cn0), .outBusy(busy0)
    );

    coin_credit_accumulator #(.MAX_CREDIT(100)) u_dut_sat (
        .clk(clk), .resetCount(resetCount),
        .inQuarter(inQuarter), .inDime(inDime), .inNickel(inNickel),
        .inVend(inVend), .inRefund(inRefund),
        .outCount(cnt1), .outVendOk(ok1), .outVendDeny(deny1), .outCoinReject(rej1),
        .outChangeQuarter(cq1), .outChangeDime(cd1), .outChangeNickel(cn1), .outBusy(busy1)
    );

    // {vend_ok, vend_deny, coin_reject, chg_quarter, chg_dime, chg_nickel, busy}
    wire [6:0] f0 = {ok0, deny0, rej0, cq0, cd0, cn0, busy0};
    wire [6:0] f1 = {ok1, deny1, rej1, cq1, cd1, cn1, busy1};

    int n_chk = 0;
    int n_err = 0;

    // Reference model: credit plus a queue of change coins still to dispense.
    int       m_max[2] = '{255, 100};
    int       m_credit[2];
    int       m_q[2][$];
    bit [6:0] m_flags[2];
    bit [4:0] m_prev = '1;

    task automatic build_change(input int k, input int amount);
        int r;
        r = amount;
        while (r >= QV) begin m_q[k].push_back(QV); r -= QV; end
        while (r >= DV) begin m_q[k].push_back(DV); r -= DV; end
        while (r >= NV) begin m_q[k].push_back(NV); r -= NV; end
    endtask

    // ins = {refund, vend, nickel, dime, quarter}
    task automatic model_cycle(input bit [4:0] ins, input bit rst);
        bit [4:0] e;
        bit any_coin;
        int sum, coin;
        bit ok, deny, rej, q, d, n;
        e = ins & ~m_prev;
        any_coin = |e[2:0];
        sum = (e[0] ? QV : 0) + (e[1] ? DV : 0) + (e[2] ? NV : 0);
        for (int k = 0; k < 2; k++) begin
            {ok, deny, rej, q, d, n} = '0;
            if (rst) begin
                m_credit[k] = 0;
                m_q[k].delete();
            end else if (m_q[k].size() > 0) begin
                coin = m_q[k].pop_front();
                m_credit[k] -= coin;
                q = (coin == QV); d = (coin == DV); n = (coin == NV);
                rej = any_coin;
            end else if (e[4] && m_credit[k] > 0) begin
                build_change(k, m_credit[k]);
                rej = any_coin;
            end else if (!e[4] && e[3]) begin
                rej = any_coin;
                if (m_credit[k] >= PRICE) begin
                    m_credit[k] -= PRICE;
                    ok = 1'b1;
                    build_change(k, m_credit[k]);
                end else begin
                    deny = 1'b1;
                end
            end else if (sum > 0) begin
                if (m_credit[k] + sum > m_max[k]) rej = 1'b1;
                else m_credit[k] += sum;
            end
            m_flags[k] = {ok, deny, rej, q, d, n, (m_q[k].size() > 0)};
        end
        m_prev = rst ? 5'b11111 : ins;
    endtask

    task automatic step(input bit [4:0] ins, input bit rst);
        {inRefund, inVend, inNickel, inDime, inQuarter} = ins;
        resetCount = rst;
        @(posedge clk);
        model_cycle(ins, rst);
        #1;
    endtask

    task automatic do_reset();
        step(5'b0, 1'b1);
        step(5'b0, 1'b1);
        step(5'b0, 1'b0);
    endtask

    task automatic test_reset();
        step(5'b0, 1'b1);
        step(5'b0, 1'b1);
        n_chk++;
        if (cnt0 !== 10'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", cnt0); end
        n_chk++;
        if (f0 !== 7'b0) begin n_err++; $display("FAIL reset_flags: got %b want 0000000", f0); end
    endtask

    task automatic test_coin_pulses();
        do_reset();
        step(5'b00001, 0);
        n_chk++;
        if (cnt0 !== 10'd25 || f0 !== 7'b0) begin n_err++; $display("FAIL quarter: got %0d/%b want 25/0000000", cnt0, f0); end
        step(5'b0, 0);
        step(5'b00010, 0);
        n_chk++;
        if (cnt0 !== 10'd35 || f0 !== 7'b0) begin n_err++; $display("FAIL dime: got %0d/%b want 35/0000000", cnt0, f0); end
        step(5'b0, 0);
        step(5'b00100, 0);
        n_chk++;
        if (cnt0 !== 10'd40 || f0 !== 7'b0) begin n_err++; $display("FAIL nickel: got %0d/%b want 40/0000000", cnt0, f0); end
    endtask

    task automatic test_held();
        do_reset();
        for (int i = 0; i < 5; i++) step(5'b00001, 0);
        step(5'b0, 0);
        n_chk++;
        if (cnt0 !== 10'd25) begin n_err++; $display("FAIL held_quarter: got %0d want 25", cnt0); end
        step(5'b00001, 1);
        step(5'b00001, 1);
        for (int i = 0; i < 3; i++) step(5'b00001, 0);
        step(5'b0, 0);
        n_chk++;
        if (cnt0 !== 10'd0 || f0 !== 7'b0) begin n_err++; $display("FAIL held_through_reset: got %0d/%b want 0/0000000", cnt0, f0); end
    endtask

    task automatic test_vend_change();
        do_reset();
        for (int i = 0; i < 3; i++) begin step(5'b00001, 0); step(5'b0, 0); end
        n_chk++;
        if (cnt0 !== 10'd75) begin n_err++; $display("FAIL vend_setup: got %0d want 75", cnt0); end
        step(5'b01000, 0);
        n_chk++;
        if (cnt0 !== 10'd10 || f0 !== 7'b1000001) begin n_err++; $display("FAIL vend_ok: got %0d/%b want 10/1000001", cnt0, f0); end
        step(5'b0, 0);
        n_chk++;
        if (cnt0 !== 10'd0 || f0 !== 7'b0000100) begin n_err++; $display("FAIL vend_change_dime: got %0d/%b want 0/0000100", cnt0, f0); end
        step(5'b0, 0);
        n_chk++;
        if (f0 !== 7'b0) begin n_err++; $display("FAIL vend_back_idle: got %b want 0000000", f0); end
    endtask

    task automatic test_deny_refund();
        do_reset();
        step(5'b00001, 0); step(5'b0, 0);
        step(5'b00010, 0); step(5'b0, 0);
        step(5'b00100, 0); step(5'b0, 0);
        step(5'b01000, 0);
        n_chk++;
        if (cnt0 !== 10'd40 || f0 !== 7'b0100000) begin n_err++; $display("FAIL vend_deny: got %0d/%b want 40/0100000", cnt0, f0); end
        step(5'b0, 0);
        step(5'b10000, 0);
        n_chk++;
        if (cnt0 !== 10'd40 || f0 !== 7'b0000001) begin n_err++; $display("FAIL refund_enter: got %0d/%b want 40/0000001", cnt0, f0); end
        step(5'b0, 0);
        n_chk++;
        if (cnt0 !== 10'd15 || f0 !== 7'b0001001) begin n_err++; $display("FAIL refund_quarter: got %0d/%b want 15/0001001", cnt0, f0); end
        step(5'b0, 0);
        n_chk++;
        if (cnt0 !== 10'd5 || f0 !== 7'b0000101) begin n_err++; $display("FAIL refund_dime: got %0d/%b want 5/0000101", cnt0, f0); end
        step(5'b0, 0);
        n_chk++;
        if (cnt0 !== 10'd0 || f0 !== 7'b0000010) begin n_err++; $display("FAIL refund_nickel: got %0d/%b want 0/0000010", cnt0, f0); end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < 4; i++) begin step(5'b00001, 0); step(5'b0, 0); end
        n_chk++;
        if (cnt1 !== 10'd100) begin n_err++; $display("FAIL sat_fill: got %0d want 100", cnt1); end
        step(5'b00001, 0);
        n_chk++;
        if (cnt1 !== 10'd100 || f1 !== 7'b0010000) begin n_err++; $display("FAIL sat_quarter: got %0d/%b want 100/0010000", cnt1, f1); end
        n_chk++;
        if (cnt0 !== 10'd125) begin n_err++; $display("FAIL sat_default_ceiling: got %0d want 125", cnt0); end
        do_reset();
        for (int i = 0; i < 3; i++) begin step(5'b00001, 0); step(5'b0, 0); end
        step(5'b00010, 0); step(5'b0, 0);
        step(5'b00100, 0); step(5'b0, 0);
        step(5'b00110, 0);
        n_chk++;
        if (cnt1 !== 10'd90 || f1 !== 7'b0010000) begin n_err++; $display("FAIL sat_dime_nickel: got %0d/%b want 90/0010000", cnt1, f1); end
    endtask

    task automatic test_reset_mid_change();
        do_reset();
        for (int i = 0; i < 8; i++) begin step(5'b00001, 0); step(5'b0, 0); end
        n_chk++;
        if (cnt0 !== 10'd200) begin n_err++; $display("FAIL midrst_setup: got %0d want 200", cnt0); end
        step(5'b10000, 0);
        step(5'b0, 0);
        n_chk++;
        if (cnt0 !== 10'd175 || f0 !== 7'b0001001) begin n_err++; $display("FAIL midrst_first_coin: got %0d/%b want 175/0001001", cnt0, f0); end
        step(5'b0, 1);
        n_chk++;
        if (cnt0 !== 10'd0 || f0 !== 7'b0) begin n_err++; $display("FAIL midrst_reset: got %0d/%b want 0/0000000", cnt0, f0); end
        for (int i = 0; i < 4; i++) begin
            step(5'b0, 0);
            n_chk++;
            if (cnt0 !== 10'd0 || f0 !== 7'b0) begin n_err++; $display("FAIL midrst_quiet[%0d]: got %0d/%b want 0/0000000", i, cnt0, f0); end
        end
    endtask

    task automatic test_random();
        bit [4:0] ins;
        bit rst;
        do_reset();
        ins = '0;
        for (int i = 0; i < 3000; i++) begin
            for (int b = 0; b < 3; b++) if ($urandom_range(0, 2) == 0) ins[b] = ~ins[b];
            if ($urandom_range(0, 5) == 0) ins[3] = ~ins[3];
            if ($urandom_range(0, 9) == 0) ins[4] = ~ins[4];
            rst = ($urandom_range(0, 249) == 0);
            step(ins, rst);
            n_chk++;
            if (cnt0 !== 10'(m_credit[0]) || f0 !== m_flags[0]) begin
                n_err++;
                $display("FAIL rand_default[%0d]: got %0d/%b want %0d/%b", i, cnt0, f0, m_credit[0], m_flags[0]);
            end
            n_chk++;
            if (cnt1 !== 10'(m_credit[1]) || f1 !== m_flags[1]) begin
                n_err++;
                $display("FAIL rand_sat[%0d]: got %0d/%b want %0d/%b", i, cnt1, f1, m_credit[1], m_flags[1]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_coin_pulses();
        test_held();
        test_vend_change();
        test_deny_refund();
        test_saturation();
        test_reset_mid_change();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/coin_credit_accumulator.md
Name: coin_credit_accumulator

Overview:
Parametrised, clocked successor to the vending-machine coin counter.
- Edge-detects quarter/dime/nickel inputs and accumulates credit with saturation and coin rejection.
- Accepts vend and refund requests, deducts a parametrised price, and dispenses change one coin per cycle via a small state machine.
- Sits between the coin-slot front end and the vend/dispense control.

Parameters:
COUNT_W, 10, width of credit register and outCount (cents)
QUARTER_VAL, 25, value of a quarter
DIME_VAL, 10, value of a dime
NICKEL_VAL, 5, value of a nickel; PRICE and all coin values are multiples of it
PRICE, 65, item price deducted on a successful vend
MAX_CREDIT, 255, saturation ceiling; must be < 2**COUNT_W

Ports:
clk  in  1  system clock, rising edge
resetCount  in  1  synchronous active-high reset
inQuarter  in  1  quarter sensor level; counted on rising edge
inDime  in  1  dime sensor level; counted on rising edge
inNickel  in  1  nickel sensor level; counted on rising edge
inVend  in  1  vend request; acted on at rising edge
inRefund  in  1  refund request; acted on at rising edge
outCount  out  COUNT_W  current credit
outVendOk  out  1  one-cycle pulse: vend accepted
outVendDeny  out  1  one-cycle pulse: vend refused, credit < PRICE
outCoinReject  out  1  one-cycle pulse: coin edge not credited
outChangeQuarter  out  1  one-cycle pulse: dispense one quarter
outChangeDime  out  1  one-cycle pulse: dispense one dime
outChangeNickel  out  1  one-cycle pulse: dispense one nickel
outBusy  out  1  high while in CHANGE state

Behaviour:
- One clock (clk). resetCount is synchronous and active-high.
- On reset: outCount=0; all pulse outputs=0; outBusy=0; state=IDLE.
- On reset, all five input-history registers are set to 1, so an input held high through reset release is not counted.
- Edge detect: edge = in & ~prev, with prev registered each cycle. An input held high counts exactly once.
- Latency: a credited edge first seen in cycle N appears on outCount after the clock edge ending cycle N. Pulses are registered and assert in cycle N+1 for 1 cycle.
- Coin sum: simultaneous coin edges in one cycle are summed, max QUARTER_VAL+DIME_VAL+NICKEL_VAL.
- Saturation: if credit+sum > MAX_CREDIT, the entire sum is rejected, credit is unchanged, and outCoinReject pulses once.
- State IDLE, priority resetCount > inRefund edge > inVend edge > coins:
  - Refund edge, credit>0: go to CHANGE.
  - Refund edge, credit==0: no-op.
  - Vend edge, credit>=PRICE: credit-=PRICE and outVendOk pulses. Go to CHANGE if the remainder is >0, else stay in IDLE.
  - Vend edge, credit<PRICE: outVendDeny pulses and credit is unchanged.
  - Any coin edge in the same cycle as an acted-on vend or refund edge is rejected (outCoinReject).
  - A vend and a refund edge in the same cycle: refund wins and the vend is ignored.
- State CHANGE, one coin per cycle, greedy:
  - credit>=QUARTER_VAL: outChangeQuarter pulses, credit-=QUARTER_VAL.
  - else credit>=DIME_VAL: outChangeDime pulses, credit-=DIME_VAL.
  - else: outChangeNickel pulses, credit-=NICKEL_VAL.
  - Return to IDLE in the cycle credit reaches 0.
  - outBusy=1 throughout CHANGE.
  - All coin edges are rejected (outCoinReject); vend and refund edges are ignored.
- Reset mid-CHANGE: the next cycle is IDLE with credit 0, and no further change pulses are issued.
- Credit never underflows: because all values are multiples of NICKEL_VAL, change is always exact.

Decomposition:
- Package coin_pkg: QUARTER_VAL/DIME_VAL/NICKEL_VAL defaults and the state enum {IDLE, CHANGE}.
- Sub-module coin_edge_detect (prev register with reset-to-1, edge output), instantiated five times.

Test Plan:
1. Reset, then single-cycle pulses inQuarter, inDime, inNickel, 2 cycles apart -> outCount 25, 35, 40; no reject pulses.
2. inQuarter held high 5 cycles, and inQuarter held high across reset release -> exactly one credit (outCount=25), and 0 for the held-through-reset case.
3. Credit 75 (3 quarters), inVend edge -> outVendOk one cycle, credit 10, outBusy high, one outChangeDime pulse, outCount 0, IDLE.
4. Credit 40, inVend edge -> outVendDeny, credit 40. Then inRefund edge -> outChangeQuarter, outChangeDime, outChangeNickel on consecutive cycles; outCount 15, 5, 0.
5. MAX_CREDIT=100: four quarters reach 100; fifth quarter -> outCoinReject, credit stays 100. Simultaneous dime+nickel at credit 90 -> rejected together.
6. Credit 200, inRefund, resetCount asserted on second CHANGE cycle -> next cycle outCount=0, outBusy=0, no change pulses thereafter.
